// File: rtl/digit_serial_addsub.sv
// ---------------------------------------------------------------------------
// digit_serial_addsub
//   Multi-cycle add/subtract unit. It processes DIGIT bits per clock, so one
//   WIDTH-bit operation takes N = WIDTH/DIGIT RUN cycles. A start/busy/done
//   handshake controls it, and every result and flag output is registered.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 2)
//   DIGIT  bits processed per cycle (1 <= DIGIT <= WIDTH, WIDTH % DIGIT == 0)
//
// Ports
//   clk       in   1      system clock, rising edge
//   rst       in   1      synchronous, active-high reset
//   start     in   1      request an operation; sampled only in IDLE
//   sel       in   1      0 = add (x+y), 1 = subtract (x-y); latched with start
//   x         in   WIDTH  operand A; latched with start
//   y         in   WIDTH  operand B; latched with start
//   busy      out  1      high while an operation is in progress
//   done      out  1      one-cycle pulse when sum and flags become valid
//   sum       out  WIDTH  result, modulo 2^WIDTH
//   c_out     out  1      carry out of the MSB (sub: 1 = no borrow)
//   overflow  out  1      signed overflow (carry into MSB ^ carry out of MSB)
//   zero      out  1      sum == 0
// ---------------------------------------------------------------------------
module digit_serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sel,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Operands shift right by one digit per RUN cycle, so the digit being
  // worked on always sits in the low DIGIT bits. The subtract selection is
  // fully captured at accept time by the inverted y and the initial carry,
  // so sel needs no separate register.
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic                   accept;
  logic                   last;
  logic [DIGIT:0]         dsum;
  logic                   msb_cin;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_next;

  // One digit of the addition, including the carry into the next digit.
  assign dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry_q};

  // Carry into the top bit of the current digit. A sum bit is a ^ b ^ cin,
  // so cin is recovered from the sum bit. In the last digit this is the
  // carry into bit WIDTH-1, which the overflow flag needs.
  assign msb_cin = dsum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];

  // The new digit enters at the top of the result and older digits move
  // down. After N cycles, digit 0 has reached the LSBs.
  assign res_cat  = {dsum[DIGIT-1:0], res_q};
  assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == LAST) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments. Every register then
  // samples values from before the edge, so the order of statements inside
  // this block does not change the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath has only flip-flops and no memory array, so every
      // register gets a defined reset value and an aborted operation leaves
      // no stale state.
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        // Subtraction is x + ~y + 1; the +1 enters as the initial carry.
        a_q     <= x;
        b_q     <= y ^ {WIDTH{sel}};
        carry_q <= sel;
        res_q   <= '0;
        cnt_q   <= '0;
        busy    <= 1'b1;
      end else if (state_q == RUN) begin
        a_q     <= a_q >> DIGIT;
        b_q     <= b_q >> DIGIT;
        carry_q <= dsum[DIGIT];
        res_q   <= res_next;
        if (last) begin
          cnt_q    <= '0;
          busy     <= 1'b0;
          done     <= 1'b1;
          sum      <= res_next;
          c_out    <= dsum[DIGIT];
          overflow <= msb_cin ^ dsum[DIGIT];
          zero     <= (res_next == '0);
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule
